// File: rtl/alu_decoder.sv
// ARM data-processing ALU decoder: maps alu_op/cmd/S to ALU select, flag-write
// enables, writeback suppression and shifter select, registered one cycle.
module alu_decoder (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       alu_op,
   input  logic       s,
   input  logic [3:0] cmd,
   output logic [2:0] alu_ctl,
   output logic [1:0] flag_w,
   output logic       no_write,
   output logic       shift
);

   typedef struct packed {
      logic [2:0] alu_ctl;
      logic [1:0] flag_w;
      logic       no_write;
      logic       shift;
   } dec_t;

   dec_t       dec_d, dec_q;
   logic [1:0] fw_arith, fw_logic;

   // {s,s} / {s,0} keep an unknown S bit visible in the flag enables
   assign fw_arith = {s, s};
   assign fw_logic = {s, 1'b0};

   always_comb begin
      dec_d = '0;
      case (alu_op)
         1'b0: dec_d = '0;
         1'b1: begin
            case (cmd)
               4'b0100: dec_d = '{3'b000, fw_arith, 1'b0, 1'b0};  // ADD
               4'b0010: dec_d = '{3'b001, fw_arith, 1'b0, 1'b0};  // SUB
               4'b0101: dec_d = '{3'b100, fw_arith, 1'b0, 1'b0};  // ADC
               4'b0000: dec_d = '{3'b010, fw_logic, 1'b0, 1'b0};  // AND
               4'b1100: dec_d = '{3'b011, fw_logic, 1'b0, 1'b0};  // ORR
               4'b0001: dec_d = '{3'b110, fw_logic, 1'b0, 1'b0};  // EOR
               4'b1010: dec_d = '{3'b001, fw_arith, 1'b1, 1'b0};  // CMP
               4'b1011: dec_d = '{3'b000, fw_arith, 1'b1, 1'b0};  // CMN
               4'b1000: dec_d = '{3'b010, fw_logic, 1'b1, 1'b0};  // TST
               4'b1001: dec_d = '{3'b110, fw_logic, 1'b1, 1'b0};  // TEQ
               // result comes from the shifter, so the ALU op is a don't-care
               4'b1101: dec_d = '{3'b0xx, fw_logic, 1'b0, 1'b1};
               4'b0011, 4'b0110, 4'b0111, 4'b1110, 4'b1111:
                        dec_d = '{3'b000, 2'b00, 1'b1, 1'b0};
               default: dec_d = 'x;  // only reachable with X/Z on cmd
            endcase
         end
         default: dec_d = 'x;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dec_q <= '0;
      else          dec_q <= dec_d;
   end

   assign alu_ctl  = dec_q.alu_ctl;
   assign flag_w   = dec_q.flag_w;
   assign no_write = dec_q.no_write;
   assign shift    = dec_q.shift;

endmodule

// File: tb/tb_alu_decoder.sv
// Scoreboard bench for alu_decoder: stimulus pushes model expectations, a
// monitor pops and compares one registered decode per clock.
module tb_alu_decoder;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       alu_op = 1'b0;
   logic       s = 1'b0;
   logic [3:0] cmd = 4'd0;
   logic [2:0] alu_ctl;
   logic [1:0] flag_w;
   logic       no_write;
   logic       shift;

   alu_decoder dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .alu_op   (alu_op),
      .s        (s),
      .cmd      (cmd),
      .alu_ctl  (alu_ctl),
      .flag_w   (flag_w),
      .no_write (no_write),
      .shift    (shift)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] val;   // {alu_ctl, flag_w, no_write, shift}
      logic [6:0] mask;  // bits that must match
      logic [3:0] cmd;
      logic       op;
      logic       sb;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Instruction table, indexed by cmd: ALU op, flag class, writes Rd, uses shifter.
   // class: 0 = unsupported, 1 = arithmetic (N,Z,C,V), 2 = logical (N,Z)
   logic [2:0] op_tab  [16] = '{3'b010, 3'b110, 3'b001, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000,
                                3'b010, 3'b110, 3'b001, 3'b000, 3'b011, 3'b000, 3'b000, 3'b000};
   int         cls_tab [16] = '{2, 2, 1, 0, 1, 1, 0, 0, 2, 2, 1, 1, 2, 2, 0, 0};
   bit         wr_tab  [16] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

   function automatic exp_t model(logic op, logic sb, logic [3:0] c);
      exp_t e;
      logic [1:0] fw;
      e.cmd = c; e.op = op; e.sb = sb;
      e.mask = 7'h7f;
      if (!op) begin
         e.val = 7'b0;
      end else begin
         fw = 2'b00;
         if (sb && cls_tab[c] == 1) fw = 2'b11;
         if (sb && cls_tab[c] == 2) fw = 2'b10;
         e.val = {op_tab[c], fw, (cls_tab[c] == 0) || !wr_tab[c], c == 4'd13};
         if (c == 4'd13) e.mask = 7'b1001111;  // MOV: alu_ctl[1:0] don't-care
      end
      return e;
   endfunction

   function automatic logic [6:0] outs();
      return {alu_ctl, flag_w, no_write, shift};
   endfunction

   task automatic chk(string name, logic [6:0] act, logic [6:0] req, logic [6:0] mask);
      total++;
      if ((act & mask) !== (req & mask)) begin
         bad++;
         $display("FAIL %s got=%b want=%b mask=%b", name, act, req, mask);
      end
   endtask

   task automatic apply(logic op, logic sb, logic [3:0] c);
      @(negedge clk);
      alu_op = op; s = sb; cmd = c;
      exp_q.push_back(model(op, sb, c));
   endtask

   // monitor: one decode per rising edge, checked just after it
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (reset_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("decode op=%0b s=%0b cmd=%b", e.op, e.sb, e.cmd), outs(), e.val, e.mask);
         end
      end
   end

   initial begin
      alu_op = 1'b1; cmd = 4'b1010; s = 1'b1;
      #1 chk("reset_async", outs(), 7'b0, 7'h7f);
      repeat (2) begin
         @(negedge clk);
         chk("reset_held", outs(), 7'b0, 7'h7f);
      end
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.push_back(model(alu_op, s, cmd));  // CMP,S=1 -> 001/11/1/0

      apply(1'b0, 1'b1, 4'b0100);
      for (int sv = 0; sv < 2; sv++) begin
         apply(1'b1, sv[0], 4'b0100);
         apply(1'b1, sv[0], 4'b0010);
         apply(1'b1, sv[0], 4'b0101);
         apply(1'b1, sv[0], 4'b0000);
         apply(1'b1, sv[0], 4'b1100);
         apply(1'b1, sv[0], 4'b0001);
      end
      apply(1'b1, 1'b1, 4'b1010);
      apply(1'b1, 1'b1, 4'b1011);
      apply(1'b1, 1'b1, 4'b1000);
      apply(1'b1, 1'b1, 4'b1001);
      apply(1'b1, 1'b0, 4'b1010);
      apply(1'b1, 1'b0, 4'b1101);
      apply(1'b1, 1'b1, 4'b1101);
      apply(1'b1, 1'b1, 4'b1110);
      for (int c = 0; c < 16; c++) apply(1'b1, 1'b1, c[3:0]);

      for (int i = 0; i < 150; i++)
         apply(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));

      // reset mid-stream: the decode in flight is dropped
      apply(1'b1, 1'b1, 4'b0101);
      #2 reset_n = 1'b0;
      exp_q.delete();
      #1 chk("reset_midstream", outs(), 7'b0, 7'h7f);
      @(posedge clk);
      #1 chk("reset_mid_held", outs(), 7'b0, 7'h7f);
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.push_back(model(alu_op, s, cmd));

      for (int i = 0; i < 100; i++)
         apply(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
